// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, imem req/ack port and IF/ID register.
// Handles branch/jump redirects, in-flight fetch kill and a one-entry stall skid.
module if_stage #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_fetch,
    input  logic             flush_decode,
    input  logic             pcsrc_decode,
    input  logic             jump_decode,
    input  logic [WIDTH-1:0] pc_branch,
    input  logic [WIDTH-1:0] pc_jump,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] instr_decode,
    output logic [WIDTH-1:0] pc_decode,
    output logic             valid_decode
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        KILL,
        HOLD
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_nxt;
    logic [WIDTH-1:0] redirect_pc;
    logic [WIDTH-1:0] redirect_nxt;
    logic [WIDTH-1:0] skid_instr;
    logic [WIDTH-1:0] skid_instr_nxt;
    logic [WIDTH-1:0] skid_pc4;
    logic [WIDTH-1:0] skid_pc4_nxt;
    logic [WIDTH-1:0] instr_nxt;
    logic [WIDTH-1:0] pcd_nxt;
    logic             valid_nxt;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] target;
    logic             flush;

    // Decode already qualifies flush with the branch outcome; pcsrc is informational.
    logic unused_pcsrc;
    assign unused_pcsrc = pcsrc_decode;

    assign pc_plus4  = pc + WIDTH'(4);
    assign target    = jump_decode ? pc_jump : pc_branch;
    assign flush     = flush_decode & ~stall_fetch;
    assign imem_req  = (state == FETCH) || (state == KILL);
    assign imem_addr = pc;

    // Next-state, PC and IF/ID selection.
    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        redirect_nxt   = redirect_pc;
        skid_instr_nxt = skid_instr;
        skid_pc4_nxt   = skid_pc4;
        instr_nxt      = instr_decode;
        pcd_nxt        = pc_decode;
        valid_nxt      = valid_decode;
        if (!stall_fetch) begin
            instr_nxt = '0;
            pcd_nxt   = '0;
            valid_nxt = 1'b0;
        end
        unique case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    if (stall_fetch) begin
                        skid_instr_nxt = imem_rdata;
                        skid_pc4_nxt   = pc_plus4;
                        pc_nxt         = pc_plus4;
                        state_nxt      = HOLD;
                    end else if (flush_decode) begin
                        pc_nxt = target;
                    end else begin
                        instr_nxt = imem_rdata;
                        pcd_nxt   = pc_plus4;
                        valid_nxt = 1'b1;
                        pc_nxt    = pc_plus4;
                    end
                end else if (flush) begin
                    redirect_nxt = target;
                    state_nxt    = KILL;
                end
            end
            KILL: begin
                if (imem_ack) begin
                    pc_nxt    = flush ? target : redirect_pc;
                    state_nxt = FETCH;
                end else if (flush) begin
                    redirect_nxt = target;
                end
            end
            HOLD: begin
                if (!stall_fetch) begin
                    state_nxt = FETCH;
                    if (flush_decode) begin
                        pc_nxt = target;
                    end else begin
                        instr_nxt = skid_instr;
                        pcd_nxt   = skid_pc4;
                        valid_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, PC, skid and IF/ID registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            redirect_pc  <= '0;
            skid_instr   <= '0;
            skid_pc4     <= '0;
            instr_decode <= '0;
            pc_decode    <= '0;
            valid_decode <= 1'b0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            redirect_pc  <= redirect_nxt;
            skid_instr   <= skid_instr_nxt;
            skid_pc4     <= skid_pc4_nxt;
            instr_decode <= instr_nxt;
            pc_decode    <= pcd_nxt;
            valid_decode <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage with a latency-configurable memory model.
// Memory returns addr ^ 32'hA5A5_0000 after lat request cycles.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall_fetch;
    logic        flush_decode;
    logic        pcsrc_decode;
    logic        jump_decode;
    logic [31:0] pc_branch;
    logic [31:0] pc_jump;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_decode;
    logic [31:0] pc_decode;
    logic        valid_decode;

    int n_err;
    int n_checks;
    int lat;
    int cnt;

    if_stage #(.WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk(clk),
        .rst(rst),
        .stall_fetch(stall_fetch),
        .flush_decode(flush_decode),
        .pcsrc_decode(pcsrc_decode),
        .jump_decode(jump_decode),
        .pc_branch(pc_branch),
        .pc_jump(pc_jump),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .instr_decode(instr_decode),
        .pc_decode(pc_decode),
        .valid_decode(valid_decode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic mem_drive();
        if (imem_req && cnt == lat - 1) begin
            imem_ack   = 1'b1;
            imem_rdata = imem_addr ^ 32'hA5A5_0000;
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = 32'h0;
        end
    endtask

    task automatic cyc();
        if (imem_req && !imem_ack) cnt++;
        else cnt = 0;
        @(posedge clk);
        #1;
        mem_drive();
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        stall_fetch  = 1'b0;
        flush_decode = 1'b0;
        pcsrc_decode = 1'b0;
        jump_decode  = 1'b0;
        imem_ack     = 1'b0;
        imem_rdata   = 32'h0;
        cnt          = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic ifid(input string tag, input logic [31:0] ins,
                        input logic [31:0] pc4, input logic v);
        check({tag, ".instr"}, instr_decode, ins);
        check({tag, ".pcd"}, pc_decode, pc4);
        check({tag, ".valid"}, {31'b0, valid_decode}, {31'b0, v});
    endtask

    initial begin
        n_err    = 0;
        n_checks = 0;
        lat      = 1;
        pc_branch = 32'h0;
        pc_jump   = 32'h0;
        rst = 1'b0;
        stall_fetch = 1'b0;
        flush_decode = 1'b0;
        pcsrc_decode = 1'b0;
        jump_decode = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = 32'h0;
        cnt = 0;
        #12;
        check("rst.req", {31'b0, imem_req}, 32'h0);
        check("rst.addr", imem_addr, 32'h0);
        ifid("rst", 32'h0, 32'h0, 1'b0);

        // zero-wait stream then 3-cycle latency
        do_reset();
        check("idle.req", {31'b0, imem_req}, 32'h0);
        lat = 1;
        cyc();
        check("z1.req", {31'b0, imem_req}, 32'h1);
        check("z1.addr", imem_addr, 32'h0);
        check("z1.valid", {31'b0, valid_decode}, 32'h0);
        cyc();
        check("z2.addr", imem_addr, 32'h4);
        ifid("z2", 32'hA5A5_0000, 32'h4, 1'b1);
        cyc();
        check("z3.addr", imem_addr, 32'h8);
        ifid("z3", 32'hA5A5_0004, 32'h8, 1'b1);
        cyc();
        check("z4.addr", imem_addr, 32'hC);
        ifid("z4", 32'hA5A5_0008, 32'hC, 1'b1);
        lat = 3;
        cyc();
        check("l1.addr", imem_addr, 32'h10);
        ifid("l1", 32'hA5A5_000C, 32'h10, 1'b1);
        cyc();
        check("l2.addr", imem_addr, 32'h10);
        ifid("l2", 32'h0, 32'h0, 1'b0);
        cyc();
        check("l3.addr", imem_addr, 32'h10);
        ifid("l3", 32'h0, 32'h0, 1'b0);
        cyc();
        check("l4.addr", imem_addr, 32'h14);
        ifid("l4", 32'hA5A5_0010, 32'h14, 1'b1);
        cyc();
        ifid("l5", 32'h0, 32'h0, 1'b0);
        cyc();
        ifid("l6", 32'h0, 32'h0, 1'b0);
        cyc();
        check("l7.addr", imem_addr, 32'h18);
        ifid("l7", 32'hA5A5_0014, 32'h18, 1'b1);

        // branch redirect coincident with ack at 0x10
        do_reset();
        lat = 1;
        for (int i = 0; i < 5; i++) cyc();
        check("br0.addr", imem_addr, 32'h10);
        check("br0.ack", {31'b0, imem_ack}, 32'h1);
        flush_decode = 1'b1;
        pcsrc_decode = 1'b1;
        pc_branch    = 32'h40;
        cyc();
        flush_decode = 1'b0;
        pcsrc_decode = 1'b0;
        check("br1.addr", imem_addr, 32'h40);
        ifid("br1", 32'h0, 32'h0, 1'b0);
        cyc();
        check("br2.addr", imem_addr, 32'h44);
        ifid("br2", 32'hA5A5_0040, 32'h44, 1'b1);

        // jump during outstanding fetch
        do_reset();
        lat = 3;
        cyc();
        flush_decode = 1'b1;
        jump_decode  = 1'b1;
        pc_jump      = 32'h100;
        cyc();
        flush_decode = 1'b0;
        jump_decode  = 1'b0;
        check("jk1.req", {31'b0, imem_req}, 32'h1);
        check("jk1.addr", imem_addr, 32'h0);
        check("jk1.valid", {31'b0, valid_decode}, 32'h0);
        cyc();
        check("jk2.addr", imem_addr, 32'h0);
        check("jk2.valid", {31'b0, valid_decode}, 32'h0);
        cyc();
        check("jk3.addr", imem_addr, 32'h100);
        check("jk3.valid", {31'b0, valid_decode}, 32'h0);
        cyc();
        check("jk4.valid", {31'b0, valid_decode}, 32'h0);
        cyc();
        check("jk5.valid", {31'b0, valid_decode}, 32'h0);
        cyc();
        ifid("jk6", 32'hA5A5_0100, 32'h104, 1'b1);

        // stall coincident with ack
        do_reset();
        lat = 1;
        cyc();
        cyc();
        ifid("st0", 32'hA5A5_0000, 32'h4, 1'b1);
        stall_fetch = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("st.req", {31'b0, imem_req}, 32'h0);
            ifid("st.hold", 32'hA5A5_0000, 32'h4, 1'b1);
        end
        stall_fetch = 1'b0;
        cyc();
        check("st4.addr", imem_addr, 32'h8);
        ifid("st4", 32'hA5A5_0004, 32'h8, 1'b1);
        cyc();
        check("st5.addr", imem_addr, 32'hC);
        ifid("st5", 32'hA5A5_0008, 32'hC, 1'b1);

        // jump priority over branch and PC wrap at the top of memory
        do_reset();
        lat = 1;
        cyc();
        flush_decode = 1'b1;
        jump_decode  = 1'b1;
        pcsrc_decode = 1'b1;
        pc_jump      = 32'hFFFF_FFFC;
        pc_branch    = 32'h40;
        cyc();
        flush_decode = 1'b0;
        jump_decode  = 1'b0;
        pcsrc_decode = 1'b0;
        check("wr1.addr", imem_addr, 32'hFFFF_FFFC);
        ifid("wr1", 32'h0, 32'h0, 1'b0);
        cyc();
        check("wr2.addr", imem_addr, 32'h0);
        ifid("wr2", 32'h5A5A_FFFC, 32'h0, 1'b1);

        // reset asserted while in KILL
        do_reset();
        lat = 1;
        cyc();
        cyc();
        lat = 3;
        cyc();
        ifid("rk0", 32'hA5A5_0004, 32'h8, 1'b1);
        flush_decode = 1'b1;
        jump_decode  = 1'b1;
        pc_jump      = 32'h100;
        cyc();
        flush_decode = 1'b0;
        jump_decode  = 1'b0;
        check("rk1.req", {31'b0, imem_req}, 32'h1);
        check("rk1.addr", imem_addr, 32'h8);
        #2;
        rst = 1'b0;
        #1;
        check("rk2.req", {31'b0, imem_req}, 32'h0);
        check("rk2.addr", imem_addr, 32'h0);
        ifid("rk2", 32'h0, 32'h0, 1'b0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        check("rk3.req", {31'b0, imem_req}, 32'h0);
        ifid("rk3", 32'h0, 32'h0, 1'b0);
        rst        = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        cnt        = 0;
        lat        = 1;
        cyc();
        check("rk4.addr", imem_addr, 32'h0);
        check("rk4.req", {31'b0, imem_req}, 32'h1);
        cyc();
        ifid("rk5", 32'hA5A5_0000, 32'h4, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage. It owns the PC register, drives a request/acknowledge instruction-memory port, and owns the IF/ID pipeline register. That register supplies `instr_decode` and `pc_decode` (PC+4) to decode. Decode returns the branch and jump redirect (`pcsrc_decode`, `jump_decode`, `pc_branch`, `pc_jump`, `flush_decode`). The hazard unit supplies `stall_fetch`.

## Interface
- `WIDTH`, default 32: data and address width.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `stall_fetch` in 1: hold the PC and IF/ID register.
- `flush_decode` in 1: redirect and squash the IF/ID register.
- `pcsrc_decode` in 1: taken branch.
- `jump_decode` in 1: jump.
- `pc_branch` in WIDTH: branch target.
- `pc_jump` in WIDTH: jump target.
- `imem_req` out 1: fetch request.
- `imem_addr` out WIDTH: fetch address, word-aligned.
- `imem_ack` in 1: one-cycle acknowledge; `imem_rdata` is valid in the same cycle.
- `imem_rdata` in WIDTH: fetched instruction.
- `instr_decode` out WIDTH: IF/ID instruction.
- `pc_decode` out WIDTH: IF/ID PC+4.
- `valid_decode` out 1: IF/ID holds a real instruction; 0 means bubble.

## Operation
- **State machine states:** IDLE, FETCH, KILL, HOLD.
- **Internal registers:**
  - `pc`
  - `redirect_pc`
  - `skid_instr` and `skid_pc4`
- **Memory handshake:**
  - `imem_req` = 1 in FETCH and KILL, 0 otherwise.
  - `imem_addr` = `pc`.
  - While `imem_req`=1 and `imem_ack`=0, `imem_addr` must not change.
  - `imem_ack` may arrive in the first request cycle.
- **Redirect target:** `jump_decode` ? `pc_jump` : `pc_branch`. Jump has priority. The target is used only when `flush_decode`=1.
- **Stall priority:** while `stall_fetch`=1, `flush_decode`, `pcsrc_decode` and `jump_decode` are ignored. The hazard unit never resolves a branch in a stalled cycle.
- **IDLE:** always moves to FETCH on the next edge.
- **FETCH, no ack:**
  - If flush (and not stalled): `redirect_pc` <= target; go to KILL.
  - Otherwise stay in FETCH.
- **FETCH, ack and flush (not stalled):**
  - Discard `imem_rdata`.
  - `pc` <= target; stay in FETCH.
- **FETCH, ack, no flush, not stalled:**
  - IF/ID <= {`imem_rdata`, `pc`+4, valid=1}.
  - `pc` <= `pc`+4; stay in FETCH.
- **FETCH, ack, stalled:**
  - `skid_instr`/`skid_pc4` <= {`imem_rdata`, `pc`+4}.
  - `pc` <= `pc`+4; go to HOLD.
- **KILL:**
  - Keep requesting the old address.
  - On ack: discard the data, `pc` <= `redirect_pc`, go to FETCH.
  - A further flush while in KILL overwrites `redirect_pc`.
- **HOLD:**
  - No request.
  - When `stall_fetch`=0 and flush: drop the skid buffer, `pc` <= target, go to FETCH.
  - When `stall_fetch`=0, no flush: IF/ID <= skid buffer with valid=1; go to FETCH.
- **IF/ID update when not stalled and no instruction is delivered** (flush, no ack, IDLE, KILL): load a bubble, i.e. `instr_decode`=0 (`sll` nop), `pc_decode`=0, `valid_decode`=0.
- **IF/ID while stalled:** holds unconditionally.
- **Arithmetic:** `pc`+4 is modulo 2^WIDTH; 32'hFFFF_FFFC wraps to 0.

## Timing
- **Reset (`rst`=0), asynchronously:**
  - state = IDLE.
  - `pc` = RESET_PC.
  - `imem_req` = 0.
  - `instr_decode` = 0, `pc_decode` = 0, `valid_decode` = 0.
  - `redirect_pc` and skid registers = 0.
- **After reset release:**
  - First edge: IDLE→FETCH.
  - `imem_req`=1 with `imem_addr`=RESET_PC in the 2nd cycle.
- **Latency:** an ack in cycle n shows the instruction on `instr_decode` in cycle n+1.
- **Throughput:** zero-wait memory (ack in every request cycle) sustains one instruction per cycle.
- **Redirect:** flush in cycle n with ack in cycle n → target on `imem_addr` in cycle n+1. Squashed slot: exactly one bubble.
- **Reset mid-operation:** `rst`=0 forces reset values immediately. An ack arriving during reset is ignored.

## Test plan
- **Reset release, zero-wait memory returning `addr`^32'hA5A5_0000:**
  - `imem_addr` sequence is 0, 4, 8.
  - `instr_decode` lags by one cycle.
  - `pc_decode` = 4, 8, 12.
  - `valid_decode`=1 from the 3rd cycle.
- **Memory with 3-cycle ack latency:**
  - `imem_addr` is stable for 3 cycles per fetch.
  - Two bubbles (`valid_decode`=0) precede each valid instruction.
- **Branch redirect:** `flush_decode`=`pcsrc_decode`=1, `pc_branch`=32'h40, coincident with ack at address 0x10.
  - Next `imem_addr`=0x40.
  - Data from 0x10 never appears.
  - One bubble is inserted.
- **Jump during outstanding fetch:** `jump_decode`=`flush_decode`=1, `pc_jump`=32'h100, ack two cycles later.
  - Old address is held until ack.
  - Next request is 0x100.
  - The killed instruction is never valid in IF/ID.
- **Stall coincident with ack:**
  - `stall_fetch`=1 for 3 cycles: IF/ID holds, `imem_req`=0 in HOLD.
  - On release, the buffered instruction enters IF/ID with the correct `pc_decode`, then fetch resumes at the next PC.
- **`rst` asserted while in KILL:**
  - All outputs return to reset values in the same cycle.
  - After release, fetch restarts at RESET_PC.
